hampel_filter: RTL

Multi-channel sliding-window Hampel outlier detector, the parametrised successor to the single-channel median/MAD calculator. Each accepted sample is written into its channel's circular window, then the window median and median absolute deviation (MAD) are computed by sequential rank selection. The sample is flagged as an outlier, and optionally replaced by the median. It sits between the sample source (ready/valid) and downstream consumers of cleaned data.

---
 rtl/hampel_filter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hampel_filter.sv
// Multi-channel sliding-window Hampel outlier detector: per-channel circular windows,
// median and MAD by sequential rank selection, scaled-MAD outlier test and optional replacement.
module hampel_filter #(
  parameter int          DATA_WIDTH = 8,
  parameter int          WIN        = 9,
  parameter int          CHANNELS   = 4,
  parameter logic [15:0] SCALE      = 16'h017C,
  parameter int          THRESH     = 3,
  localparam int         CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CW-1:0]         in_ch,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  replace_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_ch,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_median,
  output logic [DATA_WIDTH-1:0] out_mad,
  output logic [DATA_WIDTH+7:0] out_sigma,
  output logic                  out_outlier,
  output logic                  out_warm
);

  localparam int KW = $clog2(WIN + 1);
  localparam int RW = DATA_WIDTH + 48;
  localparam logic [KW-1:0] HALF = KW'((WIN - 1) / 2);
  localparam logic [KW-1:0] LAST = KW'(WIN - 1);
  localparam logic [KW-1:0] FULL = KW'(WIN);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_MED, S_DEV, S_MAD, S_SCALE, S_OUT} state_t;

  state_t state_q, state_d;
  logic                  alive_q;
  logic [CW-1:0]         ch_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic                  rep_q;
  logic [KW-1:0]         k_q;
  logic                  found_q;
  logic [DATA_WIDTH-1:0] med_q, mad_q;
  logic [DATA_WIDTH-1:0] dev_q [WIN];
  logic [DATA_WIDTH-1:0] win_q [CHANNELS][WIN];
  logic [KW-1:0]         ptr_q [CHANNELS];
  logic [KW-1:0]         fill_q [CHANNELS];

  logic [CW-1:0]         o_ch_q;
  logic [DATA_WIDTH-1:0] o_data_q, o_med_q, o_mad_q;
  logic [DATA_WIDTH+7:0] o_sigma_q;
  logic                  o_outl_q, o_warm_q;

  logic                  ch_ok;
  logic [CW-1:0]         ch_idx;
  logic [DATA_WIDTH-1:0] sel_v [WIN];
  logic [DATA_WIDTH-1:0] cand;
  logic [KW-1:0]         lt, le;
  logic                  hit;
  logic [DATA_WIDTH-1:0] dx;
  logic [DATA_WIDTH+7:0] sigma_w;
  logic                  outl_w;

  function automatic logic [DATA_WIDTH-1:0] absdiff(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign ch_ok  = int'(ch_q) < CHANNELS;
  assign ch_idx = ch_ok ? ch_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_d = S_WRITE;
      S_WRITE: begin
        if (!ch_ok)                    state_d = S_IDLE;
        else if (fill_q[ch_idx] < LAST) state_d = S_OUT;
        else                           state_d = S_MED;
      end
      S_MED:   if (k_q == LAST) state_d = S_DEV;
      S_DEV:   state_d = S_MAD;
      S_MAD:   if (k_q == LAST) state_d = S_SCALE;
      S_SCALE: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && alive_q;
    out_valid = (state_q == S_OUT);
  end

  assign out_ch      = o_ch_q;
  assign out_data    = o_data_q;
  assign out_median  = o_med_q;
  assign out_mad     = o_mad_q;
  assign out_sigma   = o_sigma_q;
  assign out_outlier = o_outl_q;
  assign out_warm    = o_warm_q;

  // One rank selector shared between the median pass (raw window) and the MAD pass (deviations).
  always_comb begin
    for (int i = 0; i < WIN; i++)
      sel_v[i] = (state_q == S_MAD) ? dev_q[i] : win_q[ch_idx][i];
  end

  always_comb begin
    cand = sel_v[k_q];
    lt   = '0;
    le   = '0;
    for (int i = 0; i < WIN; i++) begin
      if (sel_v[i] <  cand) lt = lt + KW'(1);
      if (sel_v[i] <= cand) le = le + KW'(1);
    end
    hit = (lt <= HALF) && (le > HALF);
  end

  always_comb begin
    dx      = absdiff(x_q, med_q);
    sigma_w = (DATA_WIDTH+8)'((RW'(mad_q) * RW'(SCALE)) >> 8);
    outl_w  = (RW'({dx, 8'h00}) > (RW'(THRESH) * RW'(SCALE) * RW'(mad_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q <= 1'b0;
      ch_q    <= '0;
      x_q     <= '0;
      rep_q   <= 1'b0;
      k_q     <= '0;
      found_q <= 1'b0;
      med_q   <= '0;
      mad_q   <= '0;
      for (int i = 0; i < WIN; i++) dev_q[i] <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
        for (int i = 0; i < WIN; i++) win_q[c][i] <= '0;
      end
      o_ch_q    <= '0;
      o_data_q  <= '0;
      o_med_q   <= '0;
      o_mad_q   <= '0;
      o_sigma_q <= '0;
      o_outl_q  <= 1'b0;
      o_warm_q  <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      case (state_q)
        S_IDLE: if (in_valid && in_ready) begin
          ch_q  <= in_ch;
          x_q   <= in_data;
          rep_q <= replace_en;
        end
        S_WRITE: if (ch_ok) begin
          win_q[ch_idx][ptr_q[ch_idx]] <= x_q;
          ptr_q[ch_idx]  <= (ptr_q[ch_idx] == LAST) ? '0 : ptr_q[ch_idx] + KW'(1);
          fill_q[ch_idx] <= (fill_q[ch_idx] == FULL) ? FULL : fill_q[ch_idx] + KW'(1);
          k_q     <= '0;
          found_q <= 1'b0;
          if (fill_q[ch_idx] < LAST) begin
            o_ch_q    <= ch_q;
            o_data_q  <= x_q;
            o_med_q   <= '0;
            o_mad_q   <= '0;
            o_sigma_q <= '0;
            o_outl_q  <= 1'b0;
            o_warm_q  <= 1'b0;
          end
        end
        S_MED, S_MAD: begin
          k_q     <= (k_q == LAST) ? '0 : k_q + KW'(1);
          found_q <= (k_q == LAST) ? 1'b0 : (found_q | hit);
          if (hit && !found_q) begin
            if (state_q == S_MED) med_q <= cand;
            else                  mad_q <= cand;
          end
        end
        S_DEV: for (int i = 0; i < WIN; i++) dev_q[i] <= absdiff(win_q[ch_idx][i], med_q);
        S_SCALE: begin
          o_ch_q    <= ch_q;
          o_data_q  <= (outl_w && rep_q) ? med_q : x_q;
          o_med_q   <= med_q;
          o_mad_q   <= mad_q;
          o_sigma_q <= sigma_w;
          o_outl_q  <= outl_w;
          o_warm_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
